// File: rtl/control_unit_pkg.sv
// control_unit_pkg: ALU opcodes and execute-stage FSM states
package control_unit_pkg;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_MUL
  } aluop_t;
  typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_t;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per step, low WIDTH bits kept
module mul_iter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_last
);
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [SHW-1:0]   r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= r_b[r_cnt] ? r_acc + (r_a << r_cnt) : r_acc;
      r_cnt <= r_cnt + 1'b1;
    end
  assign o_acc  = r_acc;
  // WIDTH is a power of two, so the final step is the all-ones count
  assign o_last = &r_cnt;
endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: forwarding muxes, ALU with iterative multiply, and the EX/MEM output latch
module execute_stage_mc
  import control_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGBITS = 5,
  parameter int NFWD = 2,
  localparam int SHW = $clog2(WIDTH),
  localparam int FSW = $clog2(NFWD + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      nPC,
  input  logic                  dREN,
  input  logic                  dWEN,
  input  logic                  regWr,
  input  logic [1:0]            regSel,
  input  logic [REGBITS-1:0]    regDst,
  input  logic [REGBITS-1:0]    rs,
  input  logic [REGBITS-1:0]    rt,
  input  logic [WIDTH-1:0]      rdat1,
  input  logic [WIDTH-1:0]      rdat2,
  input  logic [WIDTH-1:0]      imm,
  input  logic [SHW-1:0]        shamt,
  input  logic [3:0]            ALUOp,
  input  logic                  ALUSrc,
  input  logic [FSW-1:0]        fwdSelA,
  input  logic [FSW-1:0]        fwdSelB,
  input  logic [NFWD*WIDTH-1:0] fwdData,
  output logic [WIDTH-1:0]      nPC_next,
  output logic                  dREN_next,
  output logic                  dWEN_next,
  output logic                  regWr_next,
  output logic [1:0]            regSel_next,
  output logic [REGBITS-1:0]    regDst_next,
  output logic [WIDTH-1:0]      ALUOut_next,
  output logic [WIDTH-1:0]      rtdat,
  output logic                  equal,
  output logic                  busy
);
  ex_state_t            r_state, w_state_n;
  aluop_t               w_op;
  logic [WIDTH-1:0]     w_a, w_rtb, w_b, w_alu, w_acc, w_res;
  logic                 w_mul, w_issue, w_last, w_bubble, w_load, w_unused;
  logic [WIDTH-1:0]     r_npc, r_alu, r_rtdat;
  logic                 r_dren, r_dwen, r_regwr;
  logic [1:0]           r_regsel;
  logic [REGBITS-1:0]   r_regdst;
  assign w_op     = aluop_t'(ALUOp);
  assign w_unused = ^{rs, rt};
  // select values outside 1..NFWD fall back to the register file
  always_comb begin
    w_a   = rdat1;
    w_rtb = rdat2;
    for (int k = 1; k <= NFWD; k++) begin
      w_a   = fwdSelA == FSW'(k) ? fwdData[(k-1)*WIDTH +: WIDTH] : w_a;
      w_rtb = fwdSelB == FSW'(k) ? fwdData[(k-1)*WIDTH +: WIDTH] : w_rtb;
    end
  end
  assign w_b   = ALUSrc ? imm : w_rtb;
  assign equal = w_a == w_rtb;
  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_SLL:  w_alu = w_b << shamt;
      ALU_SRL:  w_alu = w_b >> shamt;
      ALU_SRA:  w_alu = $signed(w_b) >>> shamt;
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_NOR:  w_alu = ~(w_a | w_b);
      ALU_SLT:  w_alu = WIDTH'($signed(w_a) < $signed(w_b));
      ALU_SLTU: w_alu = WIDTH'(w_a < w_b);
      ALU_LUI:  w_alu = w_b << (WIDTH / 2);
      default:  w_alu = '0;
    endcase
  end
  assign w_mul   = w_op == ALU_MUL;
  assign w_issue = r_state == IDLE && ihit && w_mul && !flush;
  assign busy    = w_issue || r_state == MUL;
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (CLK),
    .rst    (RST),
    .i_start(w_issue),
    .i_step (r_state == MUL && !flush),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_acc  (w_acc),
    .o_last (w_last)
  );
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = w_issue ? MUL : IDLE;
      MUL:     w_state_n = flush ? IDLE : w_last ? DONE : MUL;
      DONE:    w_state_n = flush || ihit ? IDLE : DONE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_state_n;
  // the issue edge writes a bubble; the MUL instruction itself lands from DONE
  assign w_bubble = flush || w_issue;
  assign w_load   = ihit && ((r_state == IDLE && !w_mul) || r_state == DONE);
  assign w_res    = r_state == DONE ? w_acc : w_alu;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_npc    <= '0;
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_regwr  <= 1'b0;
      r_regsel <= '0;
      r_regdst <= '0;
      r_alu    <= '0;
      r_rtdat  <= '0;
    end else if (w_bubble || w_load) begin
      r_npc    <= w_bubble ? '0 : nPC;
      r_dren   <= !w_bubble && dREN;
      r_dwen   <= !w_bubble && dWEN;
      r_regwr  <= !w_bubble && regWr;
      r_regsel <= w_bubble ? '0 : regSel;
      r_regdst <= w_bubble ? '0 : regDst;
      r_alu    <= w_bubble ? '0 : w_res;
      r_rtdat  <= w_bubble ? '0 : w_rtb;
    end
  assign nPC_next    = r_npc;
  assign dREN_next   = r_dren;
  assign dWEN_next   = r_dwen;
  assign regWr_next  = r_regwr;
  assign regSel_next = r_regsel;
  assign regDst_next = r_regdst;
  assign ALUOut_next = r_alu;
  assign rtdat       = r_rtdat;
endmodule
